// File: rtl/display_pkg.sv
// Shared display constants, scanner state encoding and a width helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package display_pkg;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int COORD_W  = 11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SNAP = 2'd1,
    SCAN = 2'd2,
    DONE = 2'd3
  } scan_state_t;

  // Bits needed to hold 0..n-1, never less than one bit.
  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/scan_axis_counter.sv
// One raster axis: pixel-within-cell counter, cell index and absolute pixel coordinate.
// Latency: counts advance on the clock edge where inc is high; clr zeroes everything in one edge.
// Backpressure: none; inc is a plain enable, wrap is combinational from the current count and inc.
module scan_axis_counter #(
  parameter int CELL  = 16,
  parameter int CELLS = 40,
  parameter int CW    = display_pkg::COORD_W,
  parameter int PW    = display_pkg::width_of(CELL),
  parameter int IW    = display_pkg::width_of(CELLS)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          clr,
  input  logic          inc,
  output logic [PW-1:0] px_in_cell,
  output logic [IW-1:0] cell_idx,
  output logic [CW-1:0] coord,
  output logic          wrap
);

  localparam logic [PW-1:0] PX_MAX  = PW'(CELL - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(CELLS - 1);

  logic px_at_max;
  logic idx_at_max;

  assign px_at_max  = (px_in_cell == PX_MAX);
  assign idx_at_max = (cell_idx == IDX_MAX);

  // Leaving the last pixel of the last cell on this edge.
  assign wrap = inc & px_at_max & idx_at_max;

  // Sub-counters replace a divide: cell index steps only when the in-cell count rolls over.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      px_in_cell <= '0;
      cell_idx   <= '0;
      coord      <= '0;
    end else if (clr) begin
      px_in_cell <= '0;
      cell_idx   <= '0;
      coord      <= '0;
    end else if (inc) begin
      if (px_at_max) begin
        px_in_cell <= '0;
        if (idx_at_max) begin
          cell_idx <= '0;
          coord    <= '0;
        end else begin
          cell_idx <= cell_idx + IW'(1);
          coord    <= coord + CW'(1);
        end
      end else begin
        px_in_cell <= px_in_cell + PW'(1);
        coord      <= coord + CW'(1);
      end
    end
  end

endmodule

// File: rtl/grid_pixel_scanner.sv
// Rasterises a snapshotted ROWS x COLS one-bit board into per-pixel framebuffer writes.
// Latency: first write one cycle after SNAP; frame = W*H write cycles plus SNAP and DONE cycles.
// Backpressure: none; the framebuffer must accept one write per cycle while pixel_write is high.
module grid_pixel_scanner #(
  parameter int COLS       = 40,
  parameter int ROWS       = 10,
  parameter int CELL_W     = 16,
  parameter int CELL_H     = 48,
  parameter int COORD_W    = display_pkg::COORD_W,
  parameter int AUTO       = 1,
  parameter int GRID_LINES = 0
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               blank,
  input  logic [COLS-1:0]    grid_in [ROWS-1:0],
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               pixel_color,
  output logic               pixel_write,
  output logic               busy,
  output logic               frame_done
);

  import display_pkg::*;

  localparam int PXW = width_of(CELL_W);
  localparam int CXW = width_of(COLS);
  localparam int PYW = width_of(CELL_H);
  localparam int RYW = width_of(ROWS);

  localparam logic [PXW-1:0] PX_EDGE = PXW'(CELL_W - 1);
  localparam logic [PYW-1:0] PY_EDGE = PYW'(CELL_H - 1);

  scan_state_t state_q;
  scan_state_t state_n;

  logic [COLS-1:0] snap_q [ROWS-1:0];
  logic            blank_q;

  logic [PXW-1:0] px_in_cell;
  logic [CXW-1:0] col_idx;
  logic [PYW-1:0] py_in_cell;
  logic [RYW-1:0] row_idx;
  logic           x_wrap;
  logic           y_wrap;
  logic           cnt_clr;
  logic           cnt_inc;
  logic           cell_bit;
  logic           on_outline;

  assign cnt_clr = (state_q == SNAP);
  assign cnt_inc = (state_q == SCAN);

  scan_axis_counter #(
    .CELL  (CELL_W),
    .CELLS (COLS),
    .CW    (COORD_W),
    .PW    (PXW),
    .IW    (CXW)
  ) u_x_axis (
    .clock      (clock),
    .reset      (reset),
    .clr        (cnt_clr),
    .inc        (cnt_inc),
    .px_in_cell (px_in_cell),
    .cell_idx   (col_idx),
    .coord      (x),
    .wrap       (x_wrap)
  );

  scan_axis_counter #(
    .CELL  (CELL_H),
    .CELLS (ROWS),
    .CW    (COORD_W),
    .PW    (PYW),
    .IW    (RYW)
  ) u_y_axis (
    .clock      (clock),
    .reset      (reset),
    .clr        (cnt_clr),
    .inc        (x_wrap),
    .px_in_cell (py_in_cell),
    .cell_idx   (row_idx),
    .coord      (y),
    .wrap       (y_wrap)
  );

  // Frame sequencing: y wrapping means the bottom-right pixel is being written now.
  always_comb begin
    state_n = state_q;
    case (state_q)
      IDLE:    if ((AUTO != 0) || start) state_n = SNAP;
      SNAP:    state_n = SCAN;
      SCAN:    if (y_wrap) state_n = DONE;
      DONE:    state_n = ((AUTO != 0) || start) ? SNAP : IDLE;
      default: state_n = IDLE;
    endcase
  end

  // State plus status flags, registered from the next state so they line up with the state flop.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      pixel_write <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      state_q     <= state_n;
      pixel_write <= (state_n == SCAN);
      busy        <= (state_n == SNAP) || (state_n == SCAN);
      frame_done  <= (state_n == DONE);
    end
  end

  // Board snapshot and blank flag are frozen for the whole frame so it never tears.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < ROWS; r++) snap_q[r] <= '0;
      blank_q <= 1'b0;
    end else if (state_q == SNAP) begin
      for (int r = 0; r < ROWS; r++) snap_q[r] <= grid_in[r];
      blank_q <= blank;
    end
  end

  assign cell_bit   = snap_q[row_idx][col_idx];
  assign on_outline = (GRID_LINES != 0) && ((px_in_cell == PX_EDGE) || (py_in_cell == PY_EDGE));

  // Colour is only meaningful alongside a write; held dark otherwise.
  assign pixel_color = pixel_write & cell_bit & ~blank_q & ~on_outline;

endmodule
